// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, one imem request at a time, single-entry decode buffer.
// Latency: zero-wait memory gives request->inst_valid in 1 edge, 1 instruction per 2 cycles.
// Backpressure: HOLD stalls everything until inst_ready. Optional FETCH_ALIGN_CHECK_EN faults misaligned redirects.
`ifndef WORDSIZE
`define WORDSIZE 32
`endif

module fetch_ctrl #(
    parameter int              WIDTH     = `WORDSIZE,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             CLK,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_fault,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] pc
);

    typedef enum logic [1:0] {IDLE, REQ, KILL, HOLD} state_t;

    localparam logic [WIDTH-1:0] INC        = WIDTH'(WIDTH / 8);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] kill_addr_q, kill_addr_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic             fault_q, fault_d;
    logic             fault_pend_q, fault_pend_d;
    logic             misalign;
    logic [WIDTH-1:0] target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign target = redirect_pc & ALIGN_MASK;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VEC;
            kill_addr_q  <= RESET_VEC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fault_q      <= 1'b0;
            fault_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_addr_q  <= kill_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fault_q      <= fault_d;
            fault_pend_q <= fault_pend_d;
        end
    end

    always_comb begin
        logic             fault_go;
        logic [WIDTH-1:0] fault_pc;
        state_d      = state_q;
        pc_d         = pc_q;
        kill_addr_d  = kill_addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;
        fault_pend_d = fault_pend_q;
        fault_go     = 1'b0;
        fault_pc     = redirect_pc;

        case (state_q)
            IDLE: begin
                if (misalign) begin
                    fault_go = 1'b1;
                end else begin
                    if (redirect) pc_d = target;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    if (imem_ack) begin
                        if (misalign) fault_go = 1'b1;
                        else          pc_d     = target;
                    end else begin
                        // Access in flight: keep its address on the bus until it retires
                        kill_addr_d  = pc_q;
                        pc_d         = misalign ? redirect_pc : target;
                        fault_pend_d = misalign;
                        state_d      = KILL;
                    end
                end else if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    fault_d   = 1'b0;
                    pc_d      = pc_q + INC;
                    state_d   = HOLD;
                end
            end
            KILL: begin
                if (redirect) begin
                    if (imem_ack) begin
                        fault_pend_d = 1'b0;
                        if (misalign) begin
                            fault_go = 1'b1;
                        end else begin
                            pc_d    = target;
                            state_d = REQ;
                        end
                    end else begin
                        pc_d         = misalign ? redirect_pc : target;
                        fault_pend_d = misalign;
                    end
                end else if (imem_ack) begin
                    fault_pend_d = 1'b0;
                    if (fault_pend_q) begin
                        fault_go = 1'b1;
                        fault_pc = pc_q;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    fault_d = 1'b0;
                    if (misalign) begin
                        fault_go = 1'b1;
                    end else begin
                        pc_d    = target;
                        state_d = REQ;
                    end
                end else if (inst_ready && !fault_q) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // A faulted target is presented to decode without touching memory
        if (fault_go) begin
            state_d   = HOLD;
            fault_d   = 1'b1;
            inst_d    = '0;
            inst_pc_d = fault_pc;
            pc_d      = fault_pc;
        end
    end

    assign imem_req   = (state_q == REQ) || (state_q == KILL);
    assign imem_addr  = (state_q == KILL) ? kill_addr_q : pc_q;
    assign inst_valid = (state_q == HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = fault_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed steps plus randomized redirects/backpressure/wait states against a fetch-stream model.
module tb_fetch_ctrl;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        CLK = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;

    fetch_ctrl #(.WIDTH(32), .RESET_VEC(32'h0)) dut (
        .CLK(CLK), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_fault(inst_fault), .redirect(redirect), .redirect_pc(redirect_pc), .pc(pc)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc;      // address of the next instruction decode should receive
    int          delivered = 0;
    int          max_wait = 0;
    bit          rand_wait = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: fixed or random wait states, data = addr ^ KEY, address must hold while pending
    bit          in_acc = 1'b0;
    int          cnt = 0;
    logic [31:0] acc_addr = '0;
    always @(negedge CLK) begin
        if (imem_req === 1'b1) begin
            if (!in_acc) begin
                in_acc   = 1'b1;
                acc_addr = imem_addr;
                cnt      = rand_wait ? int'($urandom_range(max_wait, 0)) : max_wait;
                chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            end else begin
                chk("addr_stable", imem_addr, acc_addr);
            end
            if (cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ KEY;
                in_acc     = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                cnt--;
            end
        end else begin
            imem_ack = 1'b0;
            in_acc   = 1'b0;
        end
    end

    task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc);
        @(negedge CLK);
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        if (inst_valid === 1'b1 && rdy) begin
            chk("deliver_pc", inst_pc, exp_pc);
            chk("deliver_inst", inst, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (rd) exp_pc = rpc & 32'hFFFF_FFFC;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        step(1'b0, 1'b0, 32'h0);
        while (inst_valid !== 1'b1 && n < 50) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        chk(tag, {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_pc"},    pc, 32'd0);
        chk({tag, "_addr"},  imem_addr, 32'd0);
        chk({tag, "_inst"},  inst, 32'd0);
        chk({tag, "_ipc"},   inst_pc, 32'd0);
        chk({tag, "_fault"}, {31'd0, inst_fault}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s_inst, s_ipc, s_pc;
        int          d0;
        bit          rdy, rd;
        logic [31:0] rpc;

        reset = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0; exp_pc = 32'h0;
        repeat (2) @(negedge CLK);
        #1 chk_reset_outputs("rst");
        @(negedge CLK);
        reset = 1'b0;

        // Zero-wait streaming with decode always ready
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("stream_req", {31'd0, imem_req}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("stream_valid", {31'd0, inst_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 0) chk("stream_addr", imem_addr, 32'(4 * (i / 2)));
            else            chk("stream_ipc", inst_pc, 32'(4 * (i / 2)));
        end

        // Decode stall in HOLD
        wait_valid("stall_reach");
        s_inst = inst; s_ipc = inst_pc; s_pc = pc;
        chk("stall_ipc0", s_ipc, 32'h10);
        chk("stall_pc0", s_pc, 32'h14);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("stall_inst", inst, s_inst);
            chk("stall_ipc", inst_pc, s_ipc);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_pc", pc, 32'h14);
        end
        step(1'b1, 1'b0, 32'h0);

        // Redirect while a slow access is pending
        max_wait = 3;
        step(1'b0, 1'b1, 32'h100);
        chk("kill_req0", {31'd0, imem_req}, 32'd1);
        chk("kill_addr0", imem_addr, 32'h14);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("kill_req", {31'd0, imem_req}, 32'd1);
            chk("kill_addr", imem_addr, 32'h14);
        end
        step(1'b0, 1'b0, 32'h0);
        chk("kill_newaddr", imem_addr, 32'h100);
        wait_valid("kill_valid");
        chk("kill_ipc", inst_pc, 32'h100);
        chk("kill_inst", inst, 32'h100 ^ KEY);

        // Redirect in HOLD, not consumed then consumed
        max_wait = 0;
        step(1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b0, 32'h0);
        chk("hold_rd_valid", {31'd0, inst_valid}, 32'd0);
        chk("hold_rd_addr", imem_addr, 32'h200);
        wait_valid("hold_rd_reach");
        chk("hold_rd_ipc", inst_pc, 32'h200);
        step(1'b1, 1'b1, 32'h300);
        step(1'b0, 1'b0, 32'h0);
        chk("hold_rdy_valid", {31'd0, inst_valid}, 32'd0);
        chk("hold_rdy_addr", imem_addr, 32'h300);
        wait_valid("hold_rdy_reach");
        chk("hold_rdy_ipc", inst_pc, 32'h300);

        // Address wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        wait_valid("wrap_reach");
        chk("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr, 32'h0);

        // Misaligned redirect target
        wait_valid("align_reach");
        step(1'b0, 1'b1, 32'h102);
        step(1'b0, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("align_req", {31'd0, imem_req}, 32'd0);
        chk("align_valid", {31'd0, inst_valid}, 32'd1);
        chk("align_fault", {31'd0, inst_fault}, 32'd1);
        chk("align_ipc", inst_pc, 32'h102);
        chk("align_inst", inst, 32'h0);
        step(1'b0, 1'b1, 32'h100);
`else
        chk("align_req", {31'd0, imem_req}, 32'd1);
        chk("align_addr", imem_addr, 32'h100);
        chk("align_fault", {31'd0, inst_fault}, 32'd0);
`endif
        wait_valid("align_fetch");
        chk("align_fetch_ipc", inst_pc, 32'h100);
        chk("align_fetch_fault", {31'd0, inst_fault}, 32'd0);

        // Reset pulse while in KILL
        max_wait = 3;
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h400);
        chk("rk_addr0", imem_addr, 32'h104);
        step(1'b0, 1'b0, 32'h0);
        chk("rk_req", {31'd0, imem_req}, 32'd1);
        chk("rk_addr", imem_addr, 32'h104);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("rk");
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0; exp_pc = 32'h0; max_wait = 0;
        step(1'b0, 1'b0, 32'h0);
        chk("rk_restart_req", {31'd0, imem_req}, 32'd1);
        chk("rk_restart_addr", imem_addr, 32'h0);
        wait_valid("rk_restart_valid");
        chk("rk_restart_ipc", inst_pc, 32'h0);

        // Randomized backpressure, redirects and wait states
        rand_wait = 1'b1; max_wait = 2;
        d0 = delivered;
        for (int i = 0; i < 2000; i++) begin
            rdy = ($urandom_range(99, 0) < 70);
            rd  = ($urandom_range(99, 0) < 8);
            rpc = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            rpc = rpc & 32'hFFFF_FFFC;
`endif
            step(rdy, rd, rpc);
        end
        chk("rand_progress", (delivered - d0 > 100) ? 32'd1 : 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
